// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter that lends the shared 4-digit seven-segment display to one of four requesters
// and keeps the winner's 13-bit value on screen for HOLD_CYCLES cycles.
module seg_display_arbiter #(
    parameter int HOLD_CYCLES = 100_000_000,
    parameter int CNT_W       = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [51:0] req_val,
    input  logic        lock,
    output logic [3:0]  grant,
    output logic [12:0] disp_num,
    output logic [1:0]  disp_src,
    output logic        disp_valid,
    output logic        busy
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t            state;
    logic [1:0]        ptr;
    logic [CNT_W-1:0]  hold_cnt;

    logic [1:0]        win;
    logic [1:0]        idx;
    logic [12:0]       win_val;

    // Scan from the farthest candidate back to ptr so the first set bit at or after ptr wins.
    always_comb begin
        win = ptr;
        idx = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                win = idx;
            end
        end
        win_val = req_val[win*13 +: 13];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= 2'd0;
            hold_cnt   <= '0;
            grant      <= 4'b0000;
            disp_num   <= 13'd0;
            disp_src   <= 2'd0;
            disp_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    grant <= 4'b0000;
                    if (req != 4'b0000) begin
                        disp_num   <= win_val;
                        disp_src   <= win;
                        grant      <= 4'b0001 << win;
                        disp_valid <= 1'b1;
                        hold_cnt   <= HOLD_LOAD;
                        ptr        <= win + 2'd1;
                        busy       <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    grant <= 4'b0000;
                    // lock freezes the countdown so a value can be read for as long as needed.
                    if (!lock) begin
                        if (hold_cnt != '0) begin
                            hold_cnt <= hold_cnt - 1'b1;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    grant <= 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with HOLD_CYCLES=4: reset, single grant, round-robin,
// no preemption with late value changes, lock freeze, and reset mid-hold.
module tb_seg_display_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [51:0] req_val;
    logic        lock;
    logic [3:0]  grant;
    logic [12:0] disp_num;
    logic [1:0]  disp_src;
    logic        disp_valid;
    logic        busy;

    int passed = 0;
    int total  = 0;

    seg_display_arbiter #(
        .HOLD_CYCLES(4),
        .CNT_W      (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_val   (req_val),
        .lock      (lock),
        .grant     (grant),
        .disp_num  (disp_num),
        .disp_src  (disp_src),
        .disp_valid(disp_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic set_val(input int i, input logic [12:0] v);
        req_val[i*13 +: 13] = v;
    endtask

    logic [3:0] exp_grant [5];
    logic [1:0] exp_src   [5];

    initial begin
        exp_grant[0] = 4'b0001; exp_src[0] = 2'd0;
        exp_grant[1] = 4'b0010; exp_src[1] = 2'd1;
        exp_grant[2] = 4'b0100; exp_src[2] = 2'd2;
        exp_grant[3] = 4'b1000; exp_src[3] = 2'd3;
        exp_grant[4] = 4'b0001; exp_src[4] = 2'd0;

        // Reset held with all requests asserted.
        rst = 1'b1; req = 4'b1111; req_val = '0; lock = 1'b0;
        set_val(0, 13'd11); set_val(1, 13'd22); set_val(2, 13'd33); set_val(3, 13'd44);
        for (int c = 0; c < 2; c++) begin
            step();
            chk("rst_grant", 32'(grant), 32'd0);
            chk("rst_num", 32'(disp_num), 32'd0);
            chk("rst_valid", 32'(disp_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_src", 32'(disp_src), 32'd0);
        end

        // Single requester 1 with value 1234, dropping req once granted.
        rst = 1'b0; req = 4'b0010; set_val(1, 13'd1234);
        step();
        chk("t2_grant", 32'(grant), 32'b0010);
        chk("t2_num", 32'(disp_num), 32'd1234);
        chk("t2_src", 32'(disp_src), 32'd1);
        chk("t2_busy", 32'(busy), 32'd1);
        chk("t2_valid", 32'(disp_valid), 32'd1);
        req = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t2_grant_pulse", 32'(grant), 32'd0);
            chk("t2_busy_hold", 32'(busy), 32'd1);
        end
        step();
        chk("t2_busy_end", 32'(busy), 32'd0);
        chk("t2_num_kept", 32'(disp_num), 32'd1234);
        chk("t2_valid_kept", 32'(disp_valid), 32'd1);

        // Reset pulse so the pointer restarts at 0, then all four request continuously.
        rst = 1'b1; req = 4'b1111;
        set_val(0, 13'd1); set_val(1, 13'd2); set_val(2, 13'd3); set_val(3, 13'd4);
        step();
        chk("t3_rst_num", 32'(disp_num), 32'd0);
        rst = 1'b0;
        for (int g = 0; g < 5; g++) begin
            step();
            chk("t3_grant", 32'(grant), 32'(exp_grant[g]));
            chk("t3_num", 32'(disp_num), 32'(exp_src[g]) + 32'd1);
            chk("t3_src", 32'(disp_src), 32'(exp_src[g]));
            if (g == 4) req = 4'b0000;
            for (int c = 0; c < 4; c++) begin
                step();
                chk("t3_gap_grant", 32'(grant), 32'd0);
                chk("t3_gap_num", 32'(disp_num), 32'(exp_src[g]) + 32'd1);
            end
        end

        // Pointer is now 1. Requester 0 wins with 7, then requester 3 arrives mid-hold.
        req = 4'b0001; set_val(0, 13'd7);
        step();
        chk("t4_grant0", 32'(grant), 32'b0001);
        chk("t4_num7", 32'(disp_num), 32'd7);
        req = 4'b1000; set_val(3, 13'd9); set_val(0, 13'd8);
        for (int c = 0; c < 4; c++) begin
            step();
            chk("t4_no_preempt_grant", 32'(grant), 32'd0);
            chk("t4_num_stays7", 32'(disp_num), 32'd7);
        end
        step();
        chk("t4_grant3", 32'(grant), 32'b1000);
        chk("t4_num9", 32'(disp_num), 32'd9);
        chk("t4_src3", 32'(disp_src), 32'd3);
        req = 4'b0000;

        // Lock from the second hold cycle for 10 cycles.
        step();
        chk("t5_hold1_busy", 32'(busy), 32'd1);
        lock = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("t5_lock_busy", 32'(busy), 32'd1);
            chk("t5_lock_grant", 32'(grant), 32'd0);
            chk("t5_lock_num", 32'(disp_num), 32'd9);
        end
        lock = 1'b0;
        step();
        chk("t5_after1_busy", 32'(busy), 32'd1);
        step();
        chk("t5_after2_busy", 32'(busy), 32'd1);
        step();
        chk("t5_after3_busy", 32'(busy), 32'd0);

        // Lock in IDLE is ignored; grant requester 1 so the pointer becomes 2.
        lock = 1'b1; req = 4'b0010; set_val(1, 13'd8191);
        step();
        chk("t6_lock_idle_grant", 32'(grant), 32'b0010);
        chk("t6_num_max", 32'(disp_num), 32'd8191);
        lock = 1'b0; req = 4'b0000;
        step();
        chk("t6_mid_hold_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        chk("t6_rst_num", 32'(disp_num), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_valid", 32'(disp_valid), 32'd0);
        rst = 1'b0; req = 4'b1001;
        step();
        chk("t6_ptr0_grant", 32'(grant), 32'b0001);
        chk("t6_ptr0_num", 32'(disp_num), 32'd8);
        chk("t6_ptr0_src", 32'(disp_src), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
